// File: rtl/mac_pkg.sv
// Shared MAC datapath constants and word types.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mac_pkg;

  localparam int ACC_W    = 20;  // accumulator: 2 guard + 16 product + 2 fraction bits
  localparam int ACC_FRAC = 2;   // fraction LSBs dropped when narrowing
  localparam int RES_W    = 8;   // narrowed result width

  localparam int RES_MAX  = (2 ** (RES_W - 1)) - 1;  // 127
  localparam int RES_MIN  = -(2 ** (RES_W - 1));     // -128

  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic signed [RES_W-1:0] res_t;

endpackage

// File: rtl/sat_round.sv
// Combinational round-half-up of a signed word, plus signed clip of a rounded word.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller registers the results.
// Ports: din   - signed word to round (IN_W bits)
//        rnd   - din rounded half toward +inf with FRAC LSBs dropped (IN_W-FRAC+1 bits)
//        rin   - rounded word to clip (IN_W-FRAC+1 bits)
//        dout  - rin clipped to the signed OUT_W range
//        clip  - rin was outside the OUT_W range
module sat_round
  import mac_pkg::*;
#(
  parameter int IN_W  = ACC_W,
  parameter int FRAC  = ACC_FRAC,
  parameter int OUT_W = RES_W
) (
  input  logic [IN_W-1:0]      din,
  output logic [IN_W-FRAC:0]   rnd,
  input  logic [IN_W-FRAC:0]   rin,
  output logic [OUT_W-1:0]     dout,
  output logic                 clip
);

  localparam int RW = IN_W - FRAC + 1;
  localparam logic signed [IN_W:0] HALF = (IN_W + 1)'(1) << (FRAC - 1);

  // Adding half an LSB and flooring equals (din >>> FRAC) + din[FRAC-1].
  // One extra bit of headroom keeps the most positive input from wrapping.
  logic signed [IN_W:0] biased;
  assign biased = $signed({din[IN_W-1], din}) + HALF;
  assign rnd    = RW'(biased >>> FRAC);

  // Value fits in OUT_W bits only if every bit above the OUT_W sign bit
  // matches the word's own sign.
  logic clip_hi;
  logic clip_lo;
  assign clip_hi = !rin[RW-1] &&  (|rin[RW-2:OUT_W-1]);
  assign clip_lo =  rin[RW-1] && !(&rin[RW-2:OUT_W-1]);

  always_comb begin
    dout = rin[OUT_W-1:0];
    if (clip_hi) begin
      dout = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (clip_lo) begin
      dout = {1'b1, {(OUT_W-1){1'b0}}};
    end
  end

  assign clip = clip_hi | clip_lo;

endmodule

// File: rtl/acc_narrow_out.sv
// Narrows the signed accumulator to OUT_W bits (round half up, then saturate) with clip statistics.
// Latency: 2 cycles from input acceptance to out_valid; 1 sample/cycle; 2-sample capacity.
// Backpressure: in_ready = !s1_valid || !s2_valid || out_ready (combinational, no bubble).
// Ports: clk, rst (async active-low); in_valid/in_ready/in_data accumulator input;
//        out_valid/out_ready/out_data/out_sat narrowed result; clr_stats clears
//        sat_sticky/sat_count, which track accepted clipped results.
module acc_narrow_out
  import mac_pkg::*;
#(
  parameter int IN_W  = ACC_W,
  parameter int FRAC  = ACC_FRAC,
  parameter int OUT_W = RES_W,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat,
  input  logic             clr_stats,
  output logic             sat_sticky,
  output logic [CNT_W-1:0] sat_count
);

  localparam int RW = IN_W - FRAC + 1;

  logic          s1_valid;
  logic [RW-1:0] s1_r;
  logic          s2_valid;
  logic          s1_ready;
  logic          s2_ready;

  logic [RW-1:0]    rnd;
  logic [OUT_W-1:0] sat_d;
  logic             sat_c;
  logic             sat_ev;

  // Round on the input word, clip on the stage-1 register.
  sat_round #(
    .IN_W  (IN_W),
    .FRAC  (FRAC),
    .OUT_W (OUT_W)
  ) u_sat_round (
    .din  (in_data),
    .rnd  (rnd),
    .rin  (s1_r),
    .dout (sat_d),
    .clip (sat_c)
  );

  assign s2_ready  = !s2_valid || out_ready;
  assign s1_ready  = !s1_valid || s2_ready;
  assign in_ready  = s1_ready;
  assign out_valid = s2_valid;

  // A statistics event is a clipped result actually handed downstream.
  assign sat_ev = s2_valid && out_ready && out_sat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_r     <= '0;
      s2_valid <= 1'b0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else begin
      if (s1_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_r <= rnd;
        end
      end
      // Output registers only load on advance, so a stalled result holds steady.
      if (s2_ready) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= sat_d;
          out_sat  <= sat_c;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_sticky <= 1'b0;
      sat_count  <= '0;
    end else if (clr_stats) begin
      // An event in the clearing cycle lands after the clear.
      sat_sticky <= sat_ev;
      sat_count  <= sat_ev ? CNT_W'(1) : '0;
    end else if (sat_ev) begin
      sat_sticky <= 1'b1;
      if (sat_count != '1) begin
        sat_count <= sat_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_acc_narrow_out.sv
module tb_acc_narrow_out;
  import mac_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_sat;
  logic        clr_stats;
  logic        sat_sticky;
  logic [7:0]  sat_count;

  acc_narrow_out dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sat    (out_sat),
    .clr_stats  (clr_stats),
    .sat_sticky (sat_sticky),
    .sat_count  (sat_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int d;
    bit s;
    int t;
  } ent_t;

  ent_t mq[$];      // accepted samples not yet handed downstream
  ent_t log_q[$];   // output transfers, t = edge of transfer
  int   m_cnt = 0;
  bit   m_sticky = 1'b0;
  int   acc_edge;
  int   n_acc = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Round half toward +inf is floor((x + 2) / 4); then clamp to int8.
  function automatic void model(input int x, output int d, output bit s);
    int r;
    r = (x + 2) >>> 2;
    if (r > 127) begin
      d = 127;  s = 1'b1;
    end else if (r < -128) begin
      d = -128; s = 1'b1;
    end else begin
      d = r;    s = 1'b0;
    end
  endfunction

  // Cycle-by-cycle comparison against the transaction-level model.
  always @(negedge clk) begin : cmp
    bit   exp_valid;
    bit   exp_ir;
    bit   ev;
    ent_t e;
    int   d;
    bit   s;
    if (!rst) begin
      mq.delete();
      m_cnt    = 0;
      m_sticky = 1'b0;
    end else begin
      // Head of line reaches the output one edge after it entered stage 1.
      exp_valid = (mq.size() > 0) && (cyc >= mq[0].t + 1);
      chk("out_valid", out_valid, exp_valid);
      if (exp_valid) begin
        chk("out_data", $signed(out_data), mq[0].d);
        chk("out_sat", out_sat, mq[0].s);
      end
      exp_ir = (mq.size() < 2) || out_ready;
      chk("in_ready", in_ready, exp_ir);
      chk("sat_count", sat_count, m_cnt);
      chk("sat_sticky", sat_sticky, m_sticky);

      ev = 1'b0;
      if (exp_valid && out_ready) begin
        e   = mq.pop_front();
        e.t = cyc + 1;
        log_q.push_back(e);
        ev  = e.s;
      end
      if (in_valid && exp_ir) begin
        model(int'($signed(in_data)), d, s);
        mq.push_back('{d, s, cyc + 1});
      end
      if (clr_stats) begin
        m_cnt    = ev ? 1 : 0;
        m_sticky = ev;
      end else if (ev) begin
        m_sticky = 1'b1;
        if (m_cnt < 255) m_cnt++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present one sample and hold it until accepted (bounded).
  task automatic send(input int x);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = x[19:0];
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 100);
    chk("accept", in_ready, 1);
    acc_edge = cyc + 1;
    n_acc++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  int s_d[4] = '{2, -1, -2, 0};
  int c_d[7] = '{127, 127, -128, 127, 127, 127, -128};
  bit c_s[7] = '{1, 1, 1, 1, 1, 0, 0};
  int first;

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    clr_stats = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_sticky", sat_sticky, 0);
    chk("rst_count", sat_count, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("in_ready_after_rst", in_ready, 1);
    tick(1);

    // Streaming with out_ready high
    log_q.delete();
    send(6);
    first = acc_edge;
    send(-6);
    send(-10);
    send(0);
    tick(4);
    chk("stream_n", log_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < log_q.size()) begin
        chk("stream_data", log_q[i].d, s_d[i]);
        chk("stream_sat", log_q[i].s, 0);
      end
    end
    if (log_q.size() == 4) begin
      chk("stream_latency", log_q[0].t - first, 2);
      chk("stream_gapless", log_q[3].t - log_q[0].t, 3);
    end
    chk("stream_count", sat_count, 0);

    // Clipping boundaries
    log_q.delete();
    send(600);
    send(524287);
    send(-524288);
    send(511);
    send(512);
    send(508);
    send(-514);
    tick(4);
    chk("clip_n", log_q.size(), 7);
    for (int i = 0; i < 7; i++) begin
      if (i < log_q.size()) begin
        chk("clip_data", log_q[i].d, c_d[i]);
        chk("clip_sat", log_q[i].s, c_s[i]);
      end
    end
    chk("clip_count", sat_count, 5);
    chk("clip_sticky", sat_sticky, 1);

    // Backpressure: burst of 5 with the output stalled
    log_q.delete();
    n_acc = 0;
    out_ready = 1'b0;
    fork
      begin
        for (int k = 1; k <= 5; k++) send(4 * k);
      end
      begin
        tick(6);
        @(negedge clk);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_accepts", n_acc, 2);
        chk("bp_out_valid", out_valid, 1);
        for (int j = 0; j < 3; j++) begin
          chk("bp_hold", $signed(out_data), 1);
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    tick(6);
    chk("bp_n", log_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < log_q.size()) chk("bp_order", log_q[i].d, i + 1);
    end
    if (log_q.size() == 5) chk("bp_gapless", log_q[4].t - log_q[0].t, 4);

    // Counter saturates at 255
    for (int k = 0; k < 256; k++) send(600);
    tick(4);
    chk("cnt_sat", sat_count, 255);
    chk("cnt_sticky", sat_sticky, 1);

    // Clear alone
    clr_stats = 1'b1;
    tick(1);
    clr_stats = 1'b0;
    @(negedge clk);
    chk("clr_count", sat_count, 0);
    chk("clr_sticky", sat_sticky, 0);
    tick(1);

    // Clear coinciding with a clipped transfer
    send(600);
    send(600);
    tick(4);
    chk("pre_clr_count", sat_count, 2);
    out_ready = 1'b0;
    send(600);
    tick(2);
    @(negedge clk);
    chk("clr_ev_stalled", out_valid, 1);
    tick(1);
    clr_stats = 1'b1;
    out_ready = 1'b1;
    tick(1);
    clr_stats = 1'b0;
    @(negedge clk);
    chk("clr_ev_count", sat_count, 1);
    chk("clr_ev_sticky", sat_sticky, 1);
    tick(1);

    // Asynchronous reset with two samples stalled
    out_ready = 1'b0;
    send(600);
    send(8);
    tick(2);
    @(negedge clk);
    chk("stall_full", in_ready, 0);
    chk("stall_valid", out_valid, 1);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_count", sat_count, 0);
    chk("arst_sticky", sat_sticky, 0);
    repeat (2) @(negedge clk);
    log_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    out_ready = 1'b1;
    send(12);
    tick(4);
    chk("post_rst_n", log_q.size(), 1);
    if (log_q.size() > 0) begin
      chk("post_rst_data", log_q[0].d, 3);
      chk("post_rst_sat", log_q[0].s, 0);
    end
    chk("post_rst_count", sat_count, 0);
    chk("post_rst_sticky", sat_sticky, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/acc_narrow_out.md
Name: acc_narrow_out

Overview:
- Output stage of the MAC datapath; the inverse of the 16->20-bit scale/extend path.
- Takes the 20-bit signed accumulator word (2 guard MSBs, 16 product bits, 2 fraction LSBs) and narrows it to an 8-bit signed result.
- Narrowing is done by round-half-up, then signed saturation.
- Two-stage valid/ready pipeline with full backpressure, plus saturation statistics for the controller.

Parameters:
- IN_W, 20, accumulator input width (signed two's complement).
- FRAC, 2, LSBs discarded by rounding; must be >= 1.
- OUT_W, 8, output width (signed two's complement).
- CNT_W, 8, width of the saturation event counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  IN_W  signed accumulator word.
- out_valid  output  1  out_data/out_sat are valid.
- out_ready  input  1  downstream accepts the output this cycle.
- out_data  output  OUT_W  rounded, saturated signed result.
- out_sat  output  1  this result was clipped.
- clr_stats  input  1  synchronous clear of sat_sticky and sat_count.
- sat_sticky  output  1  set by any accepted clipped result.
- sat_count  output  CNT_W  number of accepted clipped results, saturating.

Behaviour:
- Reset (rst=0, asynchronous assert, synchronous-safe deassert):
  - s1_valid, s2_valid, out_valid, out_sat, sat_sticky and out_data go to 0; sat_count goes to 0.
  - Any data in flight is discarded.
  - in_ready is 1 in the first cycle after reset release.
- Handshakes:
  - A transfer occurs when valid&&ready are both high on a rising edge.
  - Valid must not depend on ready.
  - Once out_valid=1, out_data and out_sat are held stable until accepted.
- Pipeline readiness:
  - s2_ready = !s2_valid || out_ready.
  - s1_ready = !s1_valid || s2_ready.
  - in_ready = s1_ready. This is combinational from out_ready; there is no bubble.
- Stage 1 (round):
  - r = (in_data >>> FRAC) + in_data[FRAC-1], computed at IN_W-FRAC+1 bits so the +1 cannot overflow.
  - The result is registered with s1_valid.
  - Rounding is half toward +infinity: 1.5 -> 2, -1.5 -> -1, -2.5 -> -2.
- Stage 2 (saturate):
  - If r > 2^(OUT_W-1)-1 (127), out_data=127 and out_sat=1.
  - If r < -2^(OUT_W-1) (-128), out_data=-128 and out_sat=1.
  - Otherwise out_data=r[OUT_W-1:0] and out_sat=0.
  - Registered with s2_valid; out_valid = s2_valid.
- Latency and throughput:
  - 2 cycles from input acceptance to out_valid, with out_ready held high.
  - Throughput is 1 sample per cycle.
  - Ordering is preserved.
  - Capacity is 2 samples.
- Backpressure:
  - With out_ready=0, at most 2 samples are held, then in_ready=0.
  - When out_ready rises, stages 1 and 2 advance in the same cycle and in_ready=1 in that cycle.
- Statistics:
  - An event is an output transfer with out_sat=1.
  - On an event, sat_sticky becomes 1 and sat_count increments, stopping at 2^CNT_W-1 (no wrap).
  - clr_stats=1 clears both. If an event coincides with clr_stats, the event is counted after the clear: sat_count=1, sat_sticky=1.
- Stalled reset:
  - Reset asserted mid-stall empties both stages immediately.
  - Held samples are never emitted.

Decomposition:
- Shared package (mac_pkg) holds:
  - ACC_W=20, ACC_FRAC=2, RES_W=8.
  - RES_MAX=127, RES_MIN=-128.
  - The accumulator and result word typedefs.
- One natural sub-module: sat_round, a combinational round+clip function of one word. It takes a width-generic input and produces the narrowed value plus a clip flag.
- acc_narrow_out instantiates sat_round and owns the pipeline registers, handshake and counters.

Test Plan:
- Reset then streaming with out_ready=1, inputs 6, -6, -10, 0 -> outputs 2, -1, -2, 0 on cycles t+2..t+5; out_sat=0; sat_count=0.
- Clipping: inputs 600, 0x7FFFF, 0x80000, 511, 512 -> outputs 127/sat, 127/sat, -128/sat, 127/sat, 127/sat (512 rounds to 128).
  - 508 -> 127 without sat.
  - Final state: sat_count=5, sat_sticky=1.
- Backpressure:
  - out_ready=0 while driving a 5-sample burst: in_ready drops after 2 accepts and out_data holds the first sample stable.
  - Release out_ready: all 5 samples emerge in order with no gaps.
- Stats:
  - 256 clipped outputs -> sat_count stops at 255.
  - clr_stats alone -> 0/0.
  - clr_stats together with a clipped transfer -> sat_count=1, sat_sticky=1.
- Async reset: assert rst=0 mid-cycle with 2 samples stalled -> out_valid=0 immediately; after release, only new samples appear and the stats are 0.
